ep1_sweep_ctrl: RTL and testbench
=================================

EP1_SWEEP_CTRL -- requirements
Module: ep1_sweep_ctrl

Interface
REQ-001 Parameter SETTLE, default 1, settle cycles a vector is driven before its response is sampled (legal 1..15).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  begin a 32-vector sweep; honoured only in IDLE or DONE.
REQ-005 hold  input  1  pause; freezes FSM, settle counter, vector index and accumulators.
REQ-006 abcde  output  5  stimulus to the downstream 5-input logic block, {a,b,c,d,e} with a as MSB.
REQ-007 xyz  input  3  response from that block, {x,y,z} with x as MSB.
REQ-008 busy  output  1  high in DRIVE and SAMPLE.
REQ-009 done  output  1  high in DONE.
REQ-010 vec_idx  output  5  index of vector currently driven (equals abcde).
REQ-011 cnt_x, cnt_y, cnt_z  output  6 each  number of sampled vectors with x/y/z = 1 (0..32).

Function
REQ-012 FSM states SHALL be IDLE, DRIVE, SAMPLE, DONE, registered.
REQ-013 IDLE/DONE with start=1 SHALL go to DRIVE, set vec_idx=0, clear cnt_x/y/z, load settle counter with SETTLE.
REQ-014 DRIVE SHALL decrement settle counter each non-held cycle; SHALL go to SAMPLE on the cycle the counter reaches 1.
REQ-015 SAMPLE (not held) SHALL add xyz bits into cnt_x/y/z; if vec_idx=31 go to DONE, else vec_idx+1, reload counter, go to DRIVE.
REQ-016 Per-vector period SHALL be SETTLE+1 cycles; done SHALL rise 32*(SETTLE+1) edges after the edge sampling start (64 for SETTLE=1).
REQ-017 abcde SHALL equal vec_idx in every state; it SHALL hold 31 in DONE until restart.
REQ-018 start while busy SHALL be ignored; sweep continues unaffected.
REQ-019 hold=1 SHALL take priority over all transitions except rst; no sample is taken in a held SAMPLE cycle.
REQ-020 Counters SHALL be 6 bits and cannot wrap (max 32).
REQ-021 done and counts SHALL remain stable in DONE until start or rst.

Reset
REQ-022 rst=1 SHALL, at next edge and from any state including mid-sweep, force IDLE, vec_idx=0, abcde=0, busy=0, done=0, cnt_x/y/z=0, settle counter=0.
REQ-023 rst SHALL override start and hold in the same cycle.

Configuration
REQ-024 Macro EP1_SWEEP_SIG_EN defined: 16-bit output sig SHALL exist, seeded 16'hFFFF on rst and on accepted start.
REQ-025 With macro: each non-held SAMPLE, sig_next = {sig[14:0],0} ^ (sig[15] ? 16'h1021 : 0) ^ {13'b0,xyz}.
REQ-026 Without macro: sig port and its logic SHALL be absent; all other behaviour identical.

Verification (bench uses stub DUT x=a&b, y=c|d, z=^abcde)
REQ-027 rst, then start pulse, SETTLE=1 -> done rises exactly 64 edges later; cnt_x=8, cnt_y=24, cnt_z=16; abcde=31.
REQ-028 SETTLE=3, start -> done after 128 edges; counts 8/24/16; each abcde value held 4 cycles.
REQ-029 hold=1 for 10 cycles at vec_idx=5 -> vec_idx, counts frozen; done delayed by exactly 10 cycles; final counts unchanged.
REQ-030 start re-pulsed at vec_idx=12 -> ignored, done at original cycle; rst at vec_idx=20 -> next cycle IDLE, all outputs 0.
REQ-031 start in DONE -> counts cleared to 0, vec_idx=0, new sweep reproduces 8/24/16.
REQ-032 EP1_SWEEP_SIG_EN defined -> sig after sweep equals bench reference model of REQ-025; two consecutive sweeps give identical sig.

Source files
------------

// File: rtl/ep1_sweep_ctrl.sv
// ep1_sweep_ctrl: drives all 32 vectors into a 5-input block, counts x/y/z ones; optional CRC signature under EP1_SWEEP_SIG_EN
module ep1_sweep_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hold,
  output logic [4:0] abcde,
  input  logic [2:0] xyz,
  output logic       busy,
  output logic       done,
  output logic [4:0] vec_idx,
  output logic [5:0] cnt_x,
  output logic [5:0] cnt_y,
  output logic [5:0] cnt_z
`ifdef EP1_SWEEP_SIG_EN
  ,
  output logic [15:0] sig
`endif
);
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  localparam logic [3:0] SETTLE_L = 4'(SETTLE);
  state_t state_q;
  logic [3:0] settle_q;
  logic [4:0] vec_q;
  logic [5:0] cx_q, cy_q, cz_q;
  logic busy_q, done_q;
  // sweep sequencer: hold freezes everything, a new sweep may only start from IDLE or DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      settle_q <= '0;
      vec_q    <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      cz_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (!hold) begin
      case (state_q)
        IDLE, DONE: if (start) begin
          state_q  <= DRIVE;
          settle_q <= SETTLE_L;
          vec_q    <= '0;
          cx_q     <= '0;
          cy_q     <= '0;
          cz_q     <= '0;
          busy_q   <= 1'b1;
          done_q   <= 1'b0;
        end
        DRIVE: begin
          settle_q <= settle_q - 4'd1;
          if (settle_q <= 4'd1) state_q <= SAMPLE;
        end
        SAMPLE: begin
          cx_q <= cx_q + {5'd0, xyz[2]};
          cy_q <= cy_q + {5'd0, xyz[1]};
          cz_q <= cz_q + {5'd0, xyz[0]};
          if (vec_q == 5'd31) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q  <= DRIVE;
            settle_q <= SETTLE_L;
            vec_q    <= vec_q + 5'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign abcde   = vec_q;
  assign vec_idx = vec_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cnt_x   = cx_q;
  assign cnt_y   = cy_q;
  assign cnt_z   = cz_q;
`ifdef EP1_SWEEP_SIG_EN
  logic [15:0] sig_q, sig_d;
  logic accept, samp;
  // CRC-16/CCITT shift with the response bits folded into the low end
  always_comb begin
    accept = !hold && start && (state_q == IDLE || state_q == DONE);
    samp   = !hold && state_q == SAMPLE;
    sig_d  = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000) ^ {13'd0, xyz};
  end
  // signature register, reseeded at every accepted start
  always_ff @(posedge clk) begin
    if (rst || accept) sig_q <= 16'hFFFF;
    else if (samp) sig_q <= sig_d;
  end
  assign sig = sig_q;
`endif
endmodule

// File: tb/tb_ep1_sweep_ctrl.sv
// tb_ep1_sweep_ctrl: directed bench for ep1_sweep_ctrl with stub block x=a&b, y=c|d, z=^abcde
module tb_ep1_sweep_ctrl;
  logic clk = 1'b0;
  logic rst, start, start3, hold;
  logic [4:0] abcde, vec_idx, abcde3, vec_idx3;
  logic [2:0] xyz, xyz3;
  logic busy, done, busy3, done3;
  logic [5:0] cnt_x, cnt_y, cnt_z, c3x, c3y, c3z;
  int errors = 0, checks = 0, k = 0, t1, t3, bad1, bad3;
`ifdef EP1_SWEEP_SIG_EN
  logic [15:0] sig, sig3, sref, sig_a;
  logic [2:0] r;
`endif
  always #5 clk = ~clk;
  assign xyz  = {abcde[4] & abcde[3], abcde[2] | abcde[1], ^abcde};
  assign xyz3 = {abcde3[4] & abcde3[3], abcde3[2] | abcde3[1], ^abcde3};
  ep1_sweep_ctrl #(.SETTLE(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .abcde(abcde), .xyz(xyz),
    .busy(busy), .done(done), .vec_idx(vec_idx), .cnt_x(cnt_x), .cnt_y(cnt_y), .cnt_z(cnt_z)
`ifdef EP1_SWEEP_SIG_EN
    , .sig(sig)
`endif
  );
  ep1_sweep_ctrl #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .hold(1'b0), .abcde(abcde3), .xyz(xyz3),
    .busy(busy3), .done(done3), .vec_idx(vec_idx3), .cnt_x(c3x), .cnt_y(c3y), .cnt_z(c3z)
`ifdef EP1_SWEEP_SIG_EN
    , .sig(sig3)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic adv();
    @(negedge clk);
    k++;
  endtask
  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    k = 0;
    start = 1'b0;
  endtask
  task automatic wait_done(output int at);
    while (!done && k < 400) adv();
    at = k;
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; start3 = 1'b0; hold = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_vec", vec_idx, 0);
    chk("rst_abcde", abcde, 0);
    chk("rst_cnt", {cnt_x, cnt_y, cnt_z}, 0);
    chk("rst_vec3", vec_idx3, 0);
`ifdef EP1_SWEEP_SIG_EN
    chk("rst_sig", sig, 16'hFFFF);
    sref = 16'hFFFF;
    for (int v = 0; v < 32; v++) begin
      r = {v[4] & v[3], v[2] | v[1], ^v[4:0]};
      sref = {sref[14:0], 1'b0} ^ (sref[15] ? 16'h1021 : 16'h0000) ^ {13'd0, r};
    end
`endif
    // sweep A: both DUTs, SETTLE=1 and SETTLE=3
    start3 = 1'b1;
    kick();
    start3 = 1'b0;
    chk("a_busy", busy, 1);
    chk("a_vec0", vec_idx, 0);
    t1 = 0; t3 = 0; bad1 = 0; bad3 = 0;
    while ((t1 == 0 || t3 == 0) && k < 400) begin
      adv();
      if (k < 64 && abcde !== 5'(k / 2)) bad1++;
      if (k < 128 && (abcde3 !== 5'(k / 4) || vec_idx3 !== abcde3)) bad3++;
      if (done && t1 == 0) t1 = k;
      if (done3 && t3 == 0) t3 = k;
    end
    chk("a_done_edge", t1, 64);
    chk("a3_done_edge", t3, 128);
    chk("a_vec_seq", bad1, 0);
    chk("a3_vec_seq", bad3, 0);
    chk("a_cnt", {cnt_x, cnt_y, cnt_z}, {6'd8, 6'd24, 6'd16});
    chk("a3_cnt", {c3x, c3y, c3z}, {6'd8, 6'd24, 6'd16});
    chk("a_abcde31", abcde, 31);
    chk("a_busy_end", busy, 0);
`ifdef EP1_SWEEP_SIG_EN
    chk("a_sig", sig, sref);
    chk("a3_sig", sig3, sref);
    sig_a = sig;
`endif
    repeat (5) adv();
    chk("done_stable", {done, abcde, cnt_x, cnt_y, cnt_z}, {1'b1, 5'd31, 6'd8, 6'd24, 6'd16});
    // restart from DONE, hold 10 cycles at vector 5
    kick();
    chk("b_cleared", {cnt_x, cnt_y, cnt_z, vec_idx, done}, 0);
    while (k < 10) adv();
    chk("b_vec5", vec_idx, 5);
    chk("b_cnt5", {cnt_x, cnt_y, cnt_z}, {6'd0, 6'd3, 6'd3});
    hold = 1'b1;
    repeat (10) adv();
    hold = 1'b0;
    chk("b_hold_vec", vec_idx, 5);
    chk("b_hold_cnt", {cnt_x, cnt_y, cnt_z, busy}, {6'd0, 6'd3, 6'd3, 1'b1});
    wait_done(t1);
    chk("b_done_edge", t1, 74);
    chk("b_cnt", {cnt_x, cnt_y, cnt_z}, {6'd8, 6'd24, 6'd16});
`ifdef EP1_SWEEP_SIG_EN
    chk("b_sig_repeat", sig, sig_a);
`endif
    // start while busy is ignored
    kick();
    while (k < 24) adv();
    chk("c_vec12", vec_idx, 12);
    start = 1'b1;
    adv();
    start = 1'b0;
    chk("c_ignored", vec_idx, 12);
    wait_done(t1);
    chk("c_done_edge", t1, 64);
    chk("c_cnt", {cnt_x, cnt_y, cnt_z}, {6'd8, 6'd24, 6'd16});
    // reset mid-sweep, asserted together with start and hold
    kick();
    while (k < 40) adv();
    chk("d_vec20", vec_idx, 20);
    rst = 1'b1; start = 1'b1; hold = 1'b1;
    adv();
    rst = 1'b0; start = 1'b0; hold = 1'b0;
    chk("d_rst_out", {busy, done, vec_idx, abcde, cnt_x, cnt_y, cnt_z}, 0);
`ifdef EP1_SWEEP_SIG_EN
    chk("d_rst_sig", sig, 16'hFFFF);
`endif
    repeat (3) adv();
    chk("d_idle", {busy, vec_idx}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
